vga_sync: RTL and testbench
===========================

VGA_SYNC -- requirements
Module: vga_sync

Interface
REQ-001 SHALL have parameter HD, default 640: horizontal display pixels.
REQ-002 SHALL have parameter HFP, default 16: horizontal front porch, in pixels.
REQ-003 SHALL have parameter HSW, default 96: horizontal sync width, in pixels.
REQ-004 SHALL have parameter HBP, default 48: horizontal back porch, in pixels.
REQ-005 SHALL have parameter VD, default 480: vertical display lines.
REQ-006 SHALL have parameter VFP, default 10: vertical front porch, in lines.
REQ-007 SHALL have parameter VSW, default 2: vertical sync width, in lines.
REQ-008 SHALL have parameter VBP, default 33: vertical back porch, in lines.
REQ-009 SHALL have parameter SYNC_POL, default 0: active level of hsync and vsync (0 = active-low).
REQ-010 SHALL have port clk, input, 1 bit: the single system clock (50 MHz nominal).
REQ-011 SHALL have port reset_n, input, 1 bit: reset, asynchronous, active-low.
REQ-012 SHALL have port hsync, output, 1 bit: horizontal sync.
REQ-013 SHALL have port vsync, output, 1 bit: vertical sync.
REQ-014 SHALL have port video_on, output, 1 bit: high when the current pixel is inside the visible area.
REQ-015 SHALL have port p_tick, output, 1 bit: pixel-enable strobe at clk/2.
REQ-016 SHALL have port pix_x, output, 10 bits: current horizontal pixel count.
REQ-017 SHALL have port pix_y, output, 10 bits: current vertical line count.
REQ-018 SHALL have port frame_tick, output, 1 bit: one-clk pulse on the last pixel of a frame.

Function
REQ-019 SHALL derive HT = HD+HFP+HSW+HBP (default 800) and VT = VD+VFP+VSW+VBP (default 525); both SHALL be at most 1024, and elaboration SHALL fail if either exceeds it.
REQ-020 SHALL hold a 1-bit phase register that toggles on every clk edge; p_tick SHALL equal this register.
REQ-021 SHALL advance h_count by 1 only on clk edges where p_tick=1, wrapping from HT-1 to 0.
REQ-022 SHALL advance v_count by 1 only on edges where p_tick=1 and h_count=HT-1, wrapping from VT-1 to 0; this includes the simultaneous h and v wrap at (HT-1, VT-1) to (0, 0).
REQ-023 SHALL drive pix_x = h_count and pix_y = v_count directly from the counter registers.
REQ-024 SHALL register hsync, vsync and video_on from the next-state counter values, so each output is aligned with pix_x/pix_y with 0 cycles of skew.
REQ-025 SHALL assert hsync (at level SYNC_POL) exactly while HD+HFP <= h_count <= HD+HFP+HSW-1 (default 656..751); otherwise hsync SHALL be at level ~SYNC_POL.
REQ-026 SHALL assert vsync exactly while VD+VFP <= v_count <= VD+VFP+VSW-1 (default 490..491), for whole lines, regardless of h_count.
REQ-027 SHALL drive video_on = 1 exactly while h_count < HD and v_count < VD.
REQ-028 SHALL drive frame_tick = 1 for exactly one clk, in the cycle where p_tick=1, h_count=HT-1 and v_count=VT-1 (combinational decode, registered inputs only).
REQ-029 SHALL not implement a stall or enable input; timing SHALL be free-running.

Reset
REQ-030 SHALL, while reset_n=0 (asynchronous assertion), force: phase=0, h_count=0, v_count=0, video_on=0, hsync=~SYNC_POL, vsync=~SYNC_POL, frame_tick=0.
REQ-031 SHALL, on the first clk edge after reset_n rises, set phase=1 and video_on=1 with counts still at (0,0); counting SHALL then begin on the next edge.
REQ-032 SHALL, when reset_n is asserted mid-frame, discard the current frame immediately and restart from (0,0) with no partial sync pulse held.

Verification
REQ-033 Release reset, run 2 lines -> p_tick alternates 0/1 each clk; hsync period = 1600 clk; hsync low for 192 clk starting when pix_x=656.
REQ-034 Run 1 full frame -> vsync period = 840000 clk; vsync low for 3200 clk covering pix_y=490..491; frame_tick pulses exactly once, at pix_x=799, pix_y=524.
REQ-035 Per line -> video_on high for 1280 clk (pix_x 0..639) on lines 0..479, and never high on lines 480..524.
REQ-036 At the wrap point -> (799,524) steps to (0,0) on a single p_tick edge; hsync, vsync and video_on are correct on both sides of the wrap.
REQ-037 Assert reset_n=0 at pix_x=700, pix_y=491, mid-sync -> outputs go to reset values with no clk edge needed; after release, hsync/vsync return to 1 and the next frame starts at (0,0).
REQ-038 Rebuild with SYNC_POL=1 -> hsync and vsync inverted relative to REQ-033/034, and all other outputs unchanged.

Source files
------------

// File: rtl/vga_sync.sv
// vga_sync: free-running VGA timing generator with pixel strobe at clk/2.
// Sync and video_on are registered from next-state counts so they line up with pix_x/pix_y.
module vga_sync #(
    parameter int HD       = 640,
    parameter int HFP      = 16,
    parameter int HSW      = 96,
    parameter int HBP      = 48,
    parameter int VD       = 480,
    parameter int VFP      = 10,
    parameter int VSW      = 2,
    parameter int VBP      = 33,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic       clk,
    input  logic       reset_n,
    output logic       hsync,
    output logic       vsync,
    output logic       video_on,
    output logic       p_tick,
    output logic [9:0] pix_x,
    output logic [9:0] pix_y,
    output logic       frame_tick
);
    localparam int HT = HD + HFP + HSW + HBP;
    localparam int VT = VD + VFP + VSW + VBP;

    if (HT > 1024 || VT > 1024) begin : g_size_check
        $fatal(1, "vga_sync: HT or VT exceeds 1024");
    end

    logic       phase_q;
    logic [9:0] h_q, h_d, v_q, v_d;
    logic       hs_q, vs_q, vid_q;
    logic       h_end, v_end;

    always_comb begin
        h_end = h_q == 10'(HT - 1);
        v_end = v_q == 10'(VT - 1);
        h_d   = phase_q ? (h_end ? 10'd0 : h_q + 10'd1) : h_q;
        v_d   = (phase_q && h_end) ? (v_end ? 10'd0 : v_q + 10'd1) : v_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= 1'b0;
            h_q     <= '0;
            v_q     <= '0;
            hs_q    <= ~SYNC_POL;
            vs_q    <= ~SYNC_POL;
            vid_q   <= 1'b0;
        end else begin
            phase_q <= ~phase_q;
            h_q     <= h_d;
            v_q     <= v_d;
            hs_q    <= (h_d >= 10'(HD + HFP) && h_d <= 10'(HD + HFP + HSW - 1)) ? SYNC_POL : ~SYNC_POL;
            vs_q    <= (v_d >= 10'(VD + VFP) && v_d <= 10'(VD + VFP + VSW - 1)) ? SYNC_POL : ~SYNC_POL;
            vid_q   <= (h_d < 10'(HD)) && (v_d < 10'(VD));
        end
    end

    assign p_tick     = phase_q;
    assign pix_x      = h_q;
    assign pix_y      = v_q;
    assign hsync      = hs_q;
    assign vsync      = vs_q;
    assign video_on   = vid_q;
    assign frame_tick = phase_q & h_end & v_end;
endmodule

// File: tb/tb_vga_sync.sv
// tb_vga_sync: small-geometry VGA timing checked every cycle against an arithmetic model,
// for both sync polarities, with random asynchronous resets.
module tb_vga_sync;
    localparam int HD = 16, HFP = 4, HSW = 6, HBP = 5;
    localparam int VD = 10, VFP = 3, VSW = 2, VBP = 4;
    localparam int HT = HD + HFP + HSW + HBP;
    localparam int VT = VD + VFP + VSW + VBP;

    logic       clk = 1'b0;
    logic       reset_n = 1'b1;
    logic       hs0, vs0, vid0, pt0, ft0, hs1, vs1, vid1, pt1, ft1;
    logic [9:0] px0, py0, px1, py1;
    int         n = 0;
    int         n_cmp = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    vga_sync #(.HD(HD), .HFP(HFP), .HSW(HSW), .HBP(HBP), .VD(VD), .VFP(VFP), .VSW(VSW), .VBP(VBP), .SYNC_POL(1'b0)) u0 (
        .clk(clk), .reset_n(reset_n), .hsync(hs0), .vsync(vs0), .video_on(vid0),
        .p_tick(pt0), .pix_x(px0), .pix_y(py0), .frame_tick(ft0));
    vga_sync #(.HD(HD), .HFP(HFP), .HSW(HSW), .HBP(HBP), .VD(VD), .VFP(VFP), .VSW(VSW), .VBP(VBP), .SYNC_POL(1'b1)) u1 (
        .clk(clk), .reset_n(reset_n), .hsync(hs1), .vsync(vs1), .video_on(vid1),
        .p_tick(pt1), .pix_x(px1), .pix_y(py1), .frame_tick(ft1));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // clk edges since reset release; every output is a pure function of this count
    always @(posedge clk or negedge reset_n)
        if (!reset_n) n <= 0;
        else n <= n + 1;

    always @(negedge clk) begin
        int  c, eh, ev, eph;
        bit  hact, vact, evid, eft;
        c    = n / 2;
        eh   = c % HT;
        ev   = (c / HT) % VT;
        eph  = n % 2;
        hact = eh >= HD + HFP && eh < HD + HFP + HSW;
        vact = ev >= VD + VFP && ev < VD + VFP + VSW;
        evid = n > 0 && eh < HD && ev < VD;
        eft  = eph == 1 && eh == HT - 1 && ev == VT - 1;
        chk("p_tick0", pt0, eph);   chk("p_tick1", pt1, eph);
        chk("pix_x0", px0, eh);     chk("pix_x1", px1, eh);
        chk("pix_y0", py0, ev);     chk("pix_y1", py1, ev);
        chk("video0", vid0, evid);  chk("video1", vid1, evid);
        chk("frame0", ft0, eft);    chk("frame1", ft1, eft);
        chk("hsync0", hs0, !hact);  chk("hsync1", hs1, hact);
        chk("vsync0", vs0, !vact);  chk("vsync1", vs1, vact);
    end

    task automatic rst_check();
        chk("rst_pix_x", px0, 0);   chk("rst_pix_y", py0, 0);
        chk("rst_p_tick", pt0, 0);  chk("rst_video", vid0, 0);
        chk("rst_frame", ft0, 0);
        chk("rst_hsync0", hs0, 1);  chk("rst_vsync0", vs0, 1);
        chk("rst_hsync1", hs1, 0);  chk("rst_vsync1", vs1, 0);
    endtask

    task automatic release_check();
        @(posedge clk); #1;
        chk("rel_p_tick", pt0, 1);  chk("rel_video", vid0, 1);
        chk("rel_pix_x", px0, 0);   chk("rel_pix_y", py0, 0);
        chk("rel_hsync0", hs0, 1);  chk("rel_vsync0", vs0, 1);
        chk("rel_hsync1", hs1, 0);  chk("rel_vsync1", vs1, 0);
    endtask

    initial begin
        int  k, hcnt, vcnt, vidcnt, ftcnt;
        bit  hit;
        #1 reset_n = 1'b0;
        #1 rst_check();
        repeat (2) @(negedge clk);
        #2 reset_n = 1'b1;
        release_check();
        // first frame_tick lands on the last clk of the first frame
        k = 0; hit = 0;
        while (!hit && k < 4 * HT * VT) begin
            @(negedge clk); k++;
            hit = ft0;
        end
        chk("ft_timeout", hit, 1);
        chk("ft_latency", k, 2 * HT * VT - 1);
        chk("ft_pix_x", px0, HT - 1);
        chk("ft_pix_y", py0, VT - 1);
        hcnt = 0; vcnt = 0; vidcnt = 0; ftcnt = 0;
        repeat (2 * HT * VT) begin
            @(negedge clk);
            hcnt += int'(!hs0); vcnt += int'(!vs0); vidcnt += int'(vid0); ftcnt += int'(ft0);
        end
        chk("frame_hsync_clks", hcnt, 2 * HSW * VT);
        chk("frame_vsync_clks", vcnt, 2 * VSW * HT);
        chk("frame_video_clks", vidcnt, 2 * HD * VD);
        chk("frame_tick_count", ftcnt, 1);
        // reset in the middle of both sync pulses
        k = 0; hit = 0;
        while (!hit && k < 4 * HT * VT) begin
            @(negedge clk); k++;
            hit = px0 == HD + HFP + 2 && py0 == VD + VFP + 1;
        end
        chk("midsync_timeout", hit, 1);
        chk("midsync_hsync0", hs0, 0);
        #3 reset_n = 1'b0;
        #1 rst_check();
        @(negedge clk); #2 reset_n = 1'b1;
        release_check();
        for (int i = 0; i < 8; i++) begin
            repeat ($urandom_range(50, 2500)) @(negedge clk);
            #($urandom_range(1, 4)) reset_n = 1'b0;
            #1 rst_check();
            repeat ($urandom_range(0, 3)) @(negedge clk);
            #2 reset_n = 1'b1;
            release_check();
        end
        repeat (2 * HT * VT + 10) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
